// File: rtl/nvm_x1_wb_responder.sv
// Wishbone slave model of one Neuromorphic X1 64x64 NVM macro.
// Decodes PROGRAM / READ_REQ command words, acks after macro latency.
module nvm_x1_wb_responder #(
    parameter logic [31:0] ADDR_MATCH = 32'h3000_000C,
    parameter int          WR_LAT     = 8,
    parameter int          RD_LAT     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        busy_o,
    output logic        rd_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_RDREQ = 2'b10;
    localparam logic [7:0] WR_LOAD  = 8'(WR_LAT - 1);
    localparam logic [7:0] RD_LOAD  = 8'(RD_LAT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        prog_q;
    logic [5:0]  row_q;
    logic [5:0]  col_q;
    logic        half_q;
    logic        bit_q;
    logic [31:0] buf_q;
    logic [63:0] mem [64];

    logic        req;
    logic        live;
    logic [1:0]  cmd_op;
    logic        cmd_go;
    logic        unused_dat;

    assign req    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i == ADDR_MATCH);
    assign live   = wbs_stb_i & wbs_cyc_i;
    assign cmd_op = wbs_dat_i[31:30];
    assign cmd_go = req & wbs_we_i & (wbs_sel_i == 4'hF)
                  & ((cmd_op == OP_PROG) | (cmd_op == OP_RDREQ));

    assign unused_dat = ^{wbs_dat_i[29:22], wbs_dat_i[15:14],
                          wbs_dat_i[7:6], wbs_dat_i[4:1]};

    // Handshake FSM, latency counter, cell array and read buffer
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            prog_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            half_q     <= 1'b0;
            bit_q      <= 1'b0;
            buf_q      <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            busy_o     <= 1'b0;
            rd_valid_o <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            unique case (state)
                IDLE: begin
                    if (cmd_go) begin
                        prog_q <= (cmd_op == OP_PROG);
                        row_q  <= wbs_dat_i[21:16];
                        col_q  <= wbs_dat_i[13:8];
                        half_q <= wbs_dat_i[5];
                        bit_q  <= wbs_dat_i[0];
                        cnt    <= (cmd_op == OP_PROG) ? WR_LOAD : RD_LOAD;
                        busy_o <= 1'b1;
                        state  <= BUSY;
                    end else if (req & wbs_we_i) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else if (req) begin
                        wbs_ack_o  <= 1'b1;
                        wbs_dat_o  <= rd_valid_o ? buf_q : 32'h0;
                        rd_valid_o <= 1'b0;
                        state      <= ACK;
                    end
                end
                BUSY: begin
                    if (!live) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == 8'd0) begin
                        if (prog_q) begin
                            mem[row_q][col_q] <= bit_q;
                        end else begin
                            buf_q <= half_q ? mem[row_q][63:32]
                                            : mem[row_q][31:0];
                            rd_valid_o <= 1'b1;
                        end
                        busy_o    <= 1'b0;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
